afifo_wctrl_ps: RTL and testbench
=================================

AFIFO_WCTRL_PS -- requirements
Module: afifo_wctrl_ps

Interface
REQ-001 SHALL have parameter AW, default 4, meaning address width; FIFO depth is 2^AW.
REQ-002 SHALL have parameter SYNC, default 2 (min 2), meaning flop stages synchronising the read Gray pointer into wclk.
REQ-003 SHALL have parameter AF_HYST, default 2, meaning almost-full release hysteresis in words.
REQ-004 SHALL have parameter CW, default 8, meaning overflow-counter width.
REQ-005 SHALL have ports, with clock and reset first; reset wrst_n is asynchronous and active-low, and the clock is wclk:
- wclk  in  1  write clock
- wrst_n  in  1  async active-low reset
- wsrst  in  1  sync soft reset
- winc  in  1  write request
- r2w_gptr_a  in  AW+1  read Gray pointer, unsynchronised (read domain)
- afull_thr  in  AW+1  almost-full threshold, quasi-static
- werr_clr  in  1  clear sticky error
- stat_clr  in  1  clear peak level
- ram_wen  out  1  memory write enable
- ram_waddr  out  AW  memory write address
- wgptr  out  AW+1  registered write Gray pointer to read domain
- wfull  out  1  full flag
- awfull  out  1  almost-full flag (hysteretic)
- wlevel  out  AW+1  occupancy seen from write side, 0..2^AW
- wpeak  out  AW+1  maximum wlevel since last clear
- werr  out  1  sticky overflow flag
- ovf_cnt  out  CW  saturating count of rejected writes

Function
REQ-006 SHALL synchronise r2w_gptr_a through SYNC wclk flops and Gray-to-binary convert the last stage to r2w_bptr (AW+1 bits).
REQ-007 SHALL drive ram_wen = winc & ~wfull & ~wsrst, combinationally.
REQ-008 SHALL keep binary pointer wbptr (AW+1 bits) with wbptr_next = wbptr + ram_wen, modulo 2^(AW+1); ram_waddr = wbptr[AW-1:0].
REQ-009 SHALL register wgptr <= bin2gray(wbptr_next), so wgptr changes at most one bit per cycle.
REQ-010 SHALL compute lvl_next = (wbptr_next - r2w_bptr) mod 2^(AW+1) and register wlevel <= lvl_next.
REQ-011 SHALL register wfull <= (lvl_next == 2^AW).
REQ-012 SHALL set awfull when lvl_next >= afull_thr and clear it when lvl_next < max(afull_thr - AF_HYST, 0); otherwise awfull SHALL hold.
REQ-013 SHALL treat afull_thr = 0 as awfull permanently set, and afull_thr > 2^AW as awfull never set.
REQ-014 SHALL treat winc & wfull as an overflow: ram_wen = 0, no pointer move, werr set next cycle, and ovf_cnt incremented, saturating at 2^CW-1.
REQ-015 SHALL give overflow-set priority over werr_clr when both occur in the same cycle; werr_clr SHALL NOT clear ovf_cnt.
REQ-016 SHALL update wpeak <= max(wpeak, lvl_next) each cycle.
REQ-017 SHALL load wpeak <= lvl_next on stat_clr, and clear ovf_cnt to 0 on stat_clr, with priority over increment.
REQ-018 SHALL have total latency from an accepted write to the wgptr update of 1 cycle, and from a read-pointer change at r2w_gptr_a to wlevel/wfull/awfull of SYNC+1 cycles.

Reset
REQ-019 SHALL, on wrst_n low, asynchronously clear wbptr, wgptr, wlevel, wpeak, wfull, awfull, werr, ovf_cnt and all synchroniser flops to 0.
REQ-020 SHALL, on wsrst high, clear the same registers except the synchroniser flops on the next wclk edge, overriding all other updates including winc.
REQ-021 SHALL leave the synchroniser flops running during wsrst; the read side is required to be soft-reset concurrently.

Verification
REQ-022 SHALL be verified (all scenarios use AW=4, SYNC=2, AF_HYST=2) for: reset release -> all outputs 0, ram_waddr=0.
REQ-023 SHALL be verified for: 16 writes, read pointer held 0 -> wfull=1 and wlevel=16 one cycle after the 16th write; a 17th winc gives ram_wen=0, werr=1, ovf_cnt=1.
REQ-024 SHALL be verified for: afull_thr=12 -> awfull sets with wlevel=12; read advance to level 10 -> awfull stays 1; level 9 -> awfull clears SYNC+1 cycles after the r2w_gptr_a change.
REQ-025 SHALL be verified for: 40 writes interleaved with random reads -> ram_waddr wraps 15->0, wgptr Hamming distance <=1 per cycle, wlevel matches model.
REQ-026 SHALL be verified for: 300 overflow attempts with CW=8 -> ovf_cnt=255 held; werr_clr with a simultaneous overflow -> werr stays 1.
REQ-027 SHALL be verified for: wsrst asserted mid-burst with winc=1 -> ram_wen=0 that cycle; next cycle wbptr, wgptr, wlevel, wpeak, werr, ovf_cnt = 0.

Source files
------------

// File: rtl/afifo_wctrl_ps.sv
// Write-side controller of an asynchronous FIFO: read-pointer synchroniser, write
// pointer and full/almost-full generation, occupancy statistics and overflow tracking.
module afifo_wctrl_ps #(
  parameter int AW      = 4,
  parameter int SYNC    = 2,
  parameter int AF_HYST = 2,
  parameter int CW      = 8
) (
  input  logic          wclk,
  input  logic          wrst_n,
  input  logic          wsrst,
  input  logic          winc,
  input  logic [AW:0]   r2w_gptr_a,
  input  logic [AW:0]   afull_thr,
  input  logic          werr_clr,
  input  logic          stat_clr,
  output logic          ram_wen,
  output logic [AW-1:0] ram_waddr,
  output logic [AW:0]   wgptr,
  output logic          wfull,
  output logic          awfull,
  output logic [AW:0]   wlevel,
  output logic [AW:0]   wpeak,
  output logic          werr,
  output logic [CW-1:0] ovf_cnt
);

  localparam logic [AW:0]   DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW+1:0] HYST  = (AW+2)'(AF_HYST);

  logic [AW:0]   sync_q [SYNC];
  logic [AW:0]   r2w_bptr;
  logic [AW:0]   wbptr;
  logic [AW:0]   wbptr_next;
  logic [AW:0]   lvl_next;
  logic [AW:0]   peak_next;
  logic [AW+1:0] af_rel;
  logic          overflow;
  logic          awfull_next;
  logic          werr_next;
  logic [CW-1:0] ovf_next;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b = g;
    for (int i = 1; i <= AW; i++) b = b ^ (g >> i);
    return b;
  endfunction

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  // Synchroniser is only cleared by the hard reset; the read side soft-resets alongside us.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= r2w_gptr_a;
      for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign r2w_bptr   = gray2bin(sync_q[SYNC-1]);
  assign ram_wen    = winc & ~wfull & ~wsrst;
  assign overflow   = winc & wfull & ~wsrst;
  assign wbptr_next = wbptr + {{AW{1'b0}}, ram_wen};
  assign lvl_next   = wbptr_next - r2w_bptr;
  assign ram_waddr  = wbptr[AW-1:0];
  assign af_rel     = ({1'b0, afull_thr} > HYST) ? ({1'b0, afull_thr} - HYST) : '0;

  // Threshold 0 pins awfull high, a threshold beyond the depth pins it low.
  always_comb begin
    awfull_next = awfull;
    if (afull_thr == '0)
      awfull_next = 1'b1;
    else if (afull_thr > DEPTH)
      awfull_next = 1'b0;
    else if (lvl_next >= afull_thr)
      awfull_next = 1'b1;
    else if ({1'b0, lvl_next} < af_rel)
      awfull_next = 1'b0;
  end

  always_comb begin
    peak_next = (lvl_next > wpeak) ? lvl_next : wpeak;
    if (stat_clr) peak_next = lvl_next;
    werr_next = werr;
    if (overflow)
      werr_next = 1'b1;
    else if (werr_clr)
      werr_next = 1'b0;
    ovf_next = ovf_cnt;
    if (stat_clr)
      ovf_next = '0;
    else if (overflow && (ovf_cnt != {CW{1'b1}}))
      ovf_next = ovf_cnt + CW'(1);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbptr   <= '0;
      wgptr   <= '0;
      wlevel  <= '0;
      wpeak   <= '0;
      wfull   <= 1'b0;
      awfull  <= 1'b0;
      werr    <= 1'b0;
      ovf_cnt <= '0;
    end else if (wsrst) begin
      wbptr   <= '0;
      wgptr   <= '0;
      wlevel  <= '0;
      wpeak   <= '0;
      wfull   <= 1'b0;
      awfull  <= 1'b0;
      werr    <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      wbptr   <= wbptr_next;
      wgptr   <= bin2gray(wbptr_next);
      wlevel  <= lvl_next;
      wpeak   <= peak_next;
      wfull   <= (lvl_next == DEPTH);
      awfull  <= awfull_next;
      werr    <= werr_next;
      ovf_cnt <= ovf_next;
    end
  end

endmodule

// File: tb/tb_afifo_wctrl_ps.sv
// Self-checking bench for afifo_wctrl_ps: vector table, directed corner sequences
// and a randomized run checked against a counter/queue based occupancy model.
module tb_afifo_wctrl_ps;
  localparam int AW = 4, SYNC = 2, AF_HYST = 2, CW = 8;
  localparam int DEPTH = 16, PMOD = 32;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          wsrst = 1'b0, winc = 1'b0, werr_clr = 1'b0, stat_clr = 1'b0;
  logic [AW:0]   r2w_gptr_a = '0;
  logic [AW:0]   afull_thr = 5'd12;
  logic          ram_wen, wfull, awfull, werr;
  logic [AW-1:0] ram_waddr;
  logic [AW:0]   wgptr, wlevel, wpeak;
  logic [CW-1:0] ovf_cnt;

  afifo_wctrl_ps #(.AW(AW), .SYNC(SYNC), .AF_HYST(AF_HYST), .CW(CW)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .wsrst(wsrst), .winc(winc),
    .r2w_gptr_a(r2w_gptr_a), .afull_thr(afull_thr), .werr_clr(werr_clr),
    .stat_clr(stat_clr), .ram_wen(ram_wen), .ram_waddr(ram_waddr), .wgptr(wgptr),
    .wfull(wfull), .awfull(awfull), .wlevel(wlevel), .wpeak(wpeak), .werr(werr),
    .ovf_cnt(ovf_cnt)
  );

  always #5 wclk = ~wclk;

  int errors = 0;
  int checks = 0;

  // Reference model: write count, delayed view of the read count, derived flags.
  int m_wcnt, m_level, m_peak, m_ovf, w_total;
  bit m_full, m_awfull, m_werr;
  int rq[$];

  typedef struct {
    bit winc;
    bit werr_clr;
    bit exp_wen;
    int exp_level;
    bit exp_full;
    bit exp_awfull;
    bit exp_werr;
    int exp_ovf;
  } vec_t;
  vec_t tbl[18];

  function automatic int gray(int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_wcnt = 0; m_level = 0; m_peak = 0; m_ovf = 0; w_total = 0;
    m_full = 0; m_awfull = 0; m_werr = 0;
    rq.delete();
    repeat (SYNC) rq.push_back(0);
  endtask

  task automatic modelStep(input bit w, input bit s, input bit ec, input bit sc, input int rd);
    int seen, lvl, thr, rel;
    bit acc, ovf;
    rq.push_back(rd);
    seen = rq.pop_front();
    acc = w && !m_full && !s;
    ovf = w && m_full && !s;
    if (s) begin
      m_wcnt = 0; m_level = 0; m_peak = 0; m_ovf = 0;
      m_full = 0; m_awfull = 0; m_werr = 0;
      return;
    end
    if (acc) w_total++;
    m_wcnt = (m_wcnt + (acc ? 1 : 0)) % PMOD;
    lvl = (m_wcnt - seen + PMOD) % PMOD;
    m_level = lvl;
    m_full = (lvl == DEPTH);
    thr = int'(afull_thr);
    rel = (thr > AF_HYST) ? thr - AF_HYST : 0;
    if (thr == 0) m_awfull = 1;
    else if (thr > DEPTH) m_awfull = 0;
    else if (lvl >= thr) m_awfull = 1;
    else if (lvl < rel) m_awfull = 0;
    m_peak = sc ? lvl : ((lvl > m_peak) ? lvl : m_peak);
    if (ovf) m_werr = 1;
    else if (ec) m_werr = 0;
    if (sc) m_ovf = 0;
    else if (ovf && m_ovf < 255) m_ovf++;
  endtask

  task automatic checkOutput();
    chk("wlevel", wlevel, m_level);
    chk("wfull", wfull, m_full);
    chk("awfull", awfull, m_awfull);
    chk("wpeak", wpeak, m_peak);
    chk("werr", werr, m_werr);
    chk("ovf_cnt", ovf_cnt, m_ovf);
    chk("wgptr", wgptr, gray(m_wcnt));
  endtask

  task automatic applyStimulus(input bit w, input bit s, input bit ec, input bit sc,
                               input int rd, output bit wen_o);
    winc = w; wsrst = s; werr_clr = ec; stat_clr = sc;
    r2w_gptr_a = (AW+1)'(gray(rd % PMOD));
    #1;
    wen_o = ram_wen;
    chk("ram_wen", ram_wen, w && !m_full && !s);
    chk("ram_waddr", ram_waddr, m_wcnt % DEPTH);
    @(posedge wclk);
    modelStep(w, s, ec, sc, rd % PMOD);
    #1;
    checkOutput();
  endtask

  task automatic doReset(input int thr);
    winc = 0; wsrst = 0; werr_clr = 0; stat_clr = 0; r2w_gptr_a = '0;
    afull_thr = (AW+1)'(thr);
    wrst_n = 0;
    repeat (2) @(posedge wclk);
    #1 wrst_n = 1;
    modelReset();
    checkOutput();
    chk("reset_waddr", ram_waddr, 0);
    chk("reset_wen", ram_wen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit wen;
    int rd_total, cyc, prev_a;
    bit wrap_seen;
    logic [AW:0] prev_g;

    for (int i = 0; i < 16; i++)
      tbl[i] = '{1'b1, 1'b0, 1'b1, i + 1, (i == 15), (i + 1 >= 12), 1'b0, 0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 16, 1'b1, 1'b1, 1'b1, 1};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 16, 1'b1, 1'b1, 1'b0, 1};

    // Fill to full, one overflow, then clear the sticky error
    doReset(12);
    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].winc, 1'b0, tbl[i].werr_clr, 1'b0, 0, wen);
      chk($sformatf("tbl%0d_wen", i), wen, tbl[i].exp_wen);
      chk($sformatf("tbl%0d_level", i), wlevel, tbl[i].exp_level);
      chk($sformatf("tbl%0d_full", i), wfull, tbl[i].exp_full);
      chk($sformatf("tbl%0d_awfull", i), awfull, tbl[i].exp_awfull);
      chk($sformatf("tbl%0d_werr", i), werr, tbl[i].exp_werr);
      chk($sformatf("tbl%0d_ovf", i), ovf_cnt, tbl[i].exp_ovf);
    end

    // Almost-full hysteresis and sync latency of a read-pointer change
    doReset(12);
    repeat (12) applyStimulus(1, 0, 0, 0, 0, wen);
    chk("af_set_awfull", awfull, 1);
    chk("af_set_level", wlevel, 12);
    applyStimulus(0, 0, 0, 0, 1, wen);
    repeat (SYNC + 1) applyStimulus(0, 0, 0, 0, 2, wen);
    chk("af_lvl10_level", wlevel, 10);
    chk("af_lvl10_awfull", awfull, 1);
    repeat (SYNC) applyStimulus(0, 0, 0, 0, 3, wen);
    chk("af_lvl9_before", awfull, 1);
    applyStimulus(0, 0, 0, 0, 3, wen);
    chk("af_lvl9_awfull", awfull, 0);
    chk("af_lvl9_level", wlevel, 9);
    chk("af_peak_before_clr", wpeak, 12);
    applyStimulus(0, 0, 0, 1, 3, wen);
    chk("af_peak_after_clr", wpeak, 9);

    // Threshold extremes
    doReset(0);
    applyStimulus(0, 0, 0, 0, 0, wen);
    chk("thr0_awfull", awfull, 1);
    doReset(17);
    repeat (16) applyStimulus(1, 0, 0, 0, 0, wen);
    chk("thr17_full", wfull, 1);
    chk("thr17_awfull", awfull, 0);

    // Overflow counter saturation and werr_clr priority
    doReset(12);
    repeat (16) applyStimulus(1, 0, 0, 0, 0, wen);
    repeat (300) applyStimulus(1, 0, 0, 0, 0, wen);
    chk("sat_ovf", ovf_cnt, 255);
    chk("sat_werr", werr, 1);
    applyStimulus(1, 0, 1, 0, 0, wen);
    chk("clr_vs_ovf_werr", werr, 1);
    chk("clr_vs_ovf_cnt", ovf_cnt, 255);
    applyStimulus(0, 0, 1, 0, 0, wen);
    chk("clr_werr", werr, 0);
    chk("clr_keeps_ovf", ovf_cnt, 255);
    applyStimulus(0, 0, 0, 1, 0, wen);
    chk("statclr_ovf", ovf_cnt, 0);

    // Soft reset in the middle of a write burst
    doReset(12);
    repeat (18) applyStimulus(1, 0, 0, 0, 0, wen);
    for (int r = 1; r <= 4; r++) applyStimulus(0, 0, 0, 0, r, wen);
    repeat (SYNC) applyStimulus(0, 0, 0, 0, 4, wen);
    repeat (3) applyStimulus(1, 0, 0, 0, 4, wen);
    applyStimulus(1, 1, 0, 0, 0, wen);
    chk("srst_wen", wen, 0);
    chk("srst_level", wlevel, 0);
    chk("srst_peak", wpeak, 0);
    chk("srst_werr", werr, 0);
    chk("srst_ovf", ovf_cnt, 0);
    chk("srst_wgptr", wgptr, 0);
    chk("srst_waddr", ram_waddr, 0);
    repeat (SYNC) applyStimulus(0, 1, 0, 0, 0, wen);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, wen);
    chk("srst_idle_level", wlevel, 0);

    // Random writes and reads
    doReset(12);
    rd_total = 0;
    wrap_seen = 0;
    prev_a = 0;
    cyc = 0;
    while (w_total < 40 && cyc < 400) begin
      if (rd_total < w_total && $urandom_range(0, 1) == 1) rd_total++;
      prev_g = wgptr;
      applyStimulus($urandom_range(0, 3) != 0, 0, 0, 0, rd_total, wen);
      chk("wgptr_hamming", $countones(wgptr ^ prev_g) <= 1, 1);
      if (prev_a == 15 && ram_waddr == 0) wrap_seen = 1;
      prev_a = ram_waddr;
      cyc++;
    end
    chk("rand_writes_done", w_total >= 40, 1);
    chk("waddr_wrap", wrap_seen, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
